// File: rtl/double_addsub_q.sv
// Request queue in front of a strobe/ack double-precision adder core.
// a+b or a-b (via sign flip of b) results are returned in FIFO order with the request tag.
module double_addsub_q #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [63:0]               a,
    input  logic [63:0]               b,
    input  logic                      sub,
    input  logic [TAG_W-1:0]          tag,
    input  logic                      ready_in,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      dropped,
    output logic [63:0]               out,
    output logic [TAG_W-1:0]          out_tag,
    output logic                      ready_out,
    output logic                      clk,
    output logic                      rst,
    output logic [63:0]               input_a,
    output logic [63:0]               input_b,
    output logic                      input_a_stb,
    output logic                      input_b_stb,
    output logic                      output_z_ack,
    input  logic [63:0]               output_z,
    input  logic                      output_z_stb,
    input  logic                      input_a_ack,
    input  logic                      input_b_ack
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_Z, DONE} state_t;

    state_t           state;
    logic [63:0]      q_a   [DEPTH];
    logic [63:0]      q_b   [DEPTH];
    logic [TAG_W-1:0] q_tag [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [TAG_W-1:0] tag_r;
    logic             push;
    logic             pop;
    logic             a_done;
    logic             b_done;

    assign clk  = clock;
    assign rst  = ~reset_n;
    assign full = (count == CNT_W'(DEPTH));
    assign push = ready_in && !full;
    assign pop  = (state == IDLE) && (count != '0);

    // A strobe already dropped means that operand was accepted earlier.
    assign a_done = !input_a_stb || input_a_ack;
    assign b_done = !input_b_stb || input_b_ack;

    // Queue storage: subtraction is folded in as a sign flip of b.
    always_ff @(posedge clock) begin
        if (reset_n && push) begin
            q_a[wr_ptr]   <= a;
            q_b[wr_ptr]   <= {b[63] ^ sub, b[62:0]};
            q_tag[wr_ptr] <= tag;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            dropped <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
            if (ready_in && full) dropped <= 1'b1;
        end
    end

    // Core handshake sequencer; operands only change on the pop in IDLE.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            input_a      <= '0;
            input_b      <= '0;
            tag_r        <= '0;
            input_a_stb  <= 1'b0;
            input_b_stb  <= 1'b0;
            output_z_ack <= 1'b0;
            out          <= '0;
            out_tag      <= '0;
            ready_out    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        input_a     <= q_a[rd_ptr];
                        input_b     <= q_b[rd_ptr];
                        tag_r       <= q_tag[rd_ptr];
                        input_a_stb <= 1'b1;
                        input_b_stb <= 1'b1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (input_a_ack) input_a_stb <= 1'b0;
                    if (input_b_ack) input_b_stb <= 1'b0;
                    if (a_done && b_done) begin
                        output_z_ack <= 1'b1;
                        state        <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (output_z_stb) begin
                        out          <= output_z;
                        out_tag      <= tag_r;
                        output_z_ack <= 1'b0;
                        ready_out    <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    ready_out <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_double_addsub_q.sv
// Bench for double_addsub_q: behavioural adder core, result scoreboard,
// vector table, queue/handshake corner sequences and randomized traffic.
module tb_double_addsub_q;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [63:0]       a;
    logic [63:0]       b;
    logic              sub;
    logic [TAG_W-1:0]  tag;
    logic              ready_in;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              dropped;
    logic [63:0]       out;
    logic [TAG_W-1:0]  out_tag;
    logic              ready_out;
    logic              clk;
    logic              rst;
    logic [63:0]       input_a;
    logic [63:0]       input_b;
    logic              input_a_stb;
    logic              input_b_stb;
    logic              output_z_ack;
    logic [63:0]       output_z     = '0;
    logic              output_z_stb = 1'b0;
    logic              input_a_ack  = 1'b0;
    logic              input_b_ack  = 1'b0;

    double_addsub_q #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset_n(reset_n), .a(a), .b(b), .sub(sub), .tag(tag),
        .ready_in(ready_in), .full(full), .count(count), .dropped(dropped),
        .out(out), .out_tag(out_tag), .ready_out(ready_out), .clk(clk), .rst(rst),
        .input_a(input_a), .input_b(input_b), .input_a_stb(input_a_stb),
        .input_b_stb(input_b_stb), .output_z_ack(output_z_ack), .output_z(output_z),
        .output_z_stb(output_z_stb), .input_a_ack(input_a_ack), .input_b_ack(input_b_ack)
    );

    always #5 clock = ~clock;

    // Behavioural core: acks each operand after a programmable delay, then
    // presents the IEEE sum of the two operands it received.
    int          a_delay = 0, b_delay = 0, z_delay = 0;
    bit          hold_ab = 0, hold_z = 0;
    int          a_wait = 0, b_wait = 0, z_wait = 0;
    bit          a_got = 0, b_got = 0;
    logic [63:0] a_val = '0, b_val = '0;

    always @(negedge clock) begin
        input_a_ack = 1'b0;
        input_b_ack = 1'b0;
        if (output_z_stb || rst || (!input_a_stb && !input_b_stb && !output_z_ack)) begin
            output_z_stb = 1'b0;
            a_got = 0; b_got = 0; a_wait = 0; b_wait = 0; z_wait = 0;
        end
        if (input_a_stb && !a_got && !hold_ab) begin
            if (a_wait >= a_delay) begin
                input_a_ack = 1'b1; a_val = input_a; a_got = 1;
            end else a_wait++;
        end
        if (input_b_stb && !b_got && !hold_ab) begin
            if (b_wait >= b_delay) begin
                input_b_ack = 1'b1; b_val = input_b; b_got = 1;
            end else b_wait++;
        end
        if (a_got && b_got && output_z_ack && !hold_z && !output_z_stb) begin
            if (z_wait >= z_delay) begin
                output_z     = $realtobits($bitstoreal(a_val) + $bitstoreal(b_val));
                output_z_stb = 1'b1;
            end else z_wait++;
        end
    end

    typedef struct {
        logic [63:0]      va;
        logic [63:0]      vb;
        logic             vs;
        logic [TAG_W-1:0] vt;
        logic [63:0]      vz;
    } vec_t;

    int               tests = 0;
    int               fails = 0;
    int               pulses = 0;
    logic [63:0]      exp_z[$];
    logic [TAG_W-1:0] exp_t[$];

    function automatic logic [63:0] ref_result(input logic [63:0] xa, input logic [63:0] xb,
                                               input logic xs);
        real ra, rb;
        ra = $bitstoreal(xa);
        rb = $bitstoreal(xb);
        return $realtobits(xs ? ra - rb : ra + rb);
    endfunction

    function automatic logic [63:0] rnd_double();
        logic [63:0] v;
        v[63]    = 1'($urandom_range(0, 1));
        v[62:52] = 11'($urandom_range(1003, 1043));
        v[51:32] = 20'($urandom);
        v[31:0]  = $urandom;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (ready_out) begin
            pulses++;
            if (exp_z.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_ready_out: got out_tag=%0d, required no result", out_tag);
            end else begin
                chk("out", out, exp_z.pop_front());
                chk("out_tag", 64'(out_tag), 64'(exp_t.pop_front()));
            end
        end
    endtask

    task automatic push(input logic [63:0] xa, input logic [63:0] xb, input logic xs,
                        input logic [TAG_W-1:0] xt, input bit acc, input logic [63:0] xz);
        a = xa; b = xb; sub = xs; tag = xt; ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        if (acc) begin
            exp_z.push_back(xz);
            exp_t.push_back(xt);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_z.size() != 0 && n < budget) begin tick(); n++; end
        if (exp_z.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d results outstanding, required 0", exp_z.size());
            exp_z.delete(); exp_t.delete();
        end
        tick(); tick();
    endtask

    task automatic wait_ready_out(input int budget);
        int n = 0;
        do begin tick(); n++; end while (!ready_out && n < budget);
        if (!ready_out) begin
            tests++; fails++;
            $display("FAIL ready_out_timeout: got no pulse in %0d cycles, required one", budget);
        end
    endtask

    task automatic do_reset();
        exp_z.delete(); exp_t.delete();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    vec_t vt[5];
    int   exp_cnt[6] = '{1, 1, 2, 3, 4, 4};

    initial begin
        int n;
        logic [63:0] ra, rb;
        logic        rs;

        vt[0] = '{64'h3FF3AE147AE147AE, 64'h40123D70A3D70A3D, 1'b0, 4'd1, 64'h401728F5C28F5C28};
        vt[1] = '{64'h40E7FF26B851EB85, 64'h40DBBC53851EB852, 1'b1, 4'd2, 64'h40D441F9EB851EB8};
        vt[2] = '{64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1, 4'd3, 64'h0000000000000000};
        vt[3] = '{64'h4000000000000000, 64'hBFE0000000000000, 1'b0, 4'd4, 64'h3FF8000000000000};
        vt[4] = '{64'h3FF0000000000000, 64'hC000000000000000, 1'b1, 4'd5, 64'h4008000000000000};

        // Reset with a push presented: it must be ignored.
        reset_n = 1'b0; ready_in = 1'b1; a = 64'h3FF0000000000000; b = a; sub = 1'b0; tag = 4'd9;
        tick(); tick();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_dropped", 64'(dropped), 64'd0);
        chk("rst_ready_out", 64'(ready_out), 64'd0);
        chk("rst_out", out, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_a_stb", 64'(input_a_stb), 64'd0);
        chk("rst_b_stb", 64'(input_b_stb), 64'd0);
        chk("rst_z_ack", 64'(output_z_ack), 64'd0);
        chk("rst_input_a", input_a, 64'd0);
        chk("rst_input_b", input_b, 64'd0);
        chk("rst_core_rst", 64'(rst), 64'd1);
        ready_in = 1'b0; reset_n = 1'b1;
        tick();
        chk("post_rst_count", 64'(count), 64'd0);
        chk("post_rst_core_rst", 64'(rst), 64'd0);

        for (int i = 0; i < 5; i++) begin
            push(vt[i].va, vt[i].vb, vt[i].vs, vt[i].vt, 1, vt[i].vz);
            drain(100);
        end

        // b acked three cycles before a.
        a_delay = 3; b_delay = 0;
        push(64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 4'd6, 1, 64'h4008000000000000);
        n = 0; while (!input_b_stb && n < 20) begin tick(); n++; end
        n = 0; while (input_b_stb && n < 20) begin tick(); n++; end
        chk("b_stb_dropped", 64'(input_b_stb), 64'd0);
        chk("a_stb_held", 64'(input_a_stb), 64'd1);
        chk("zack_before_a", 64'(output_z_ack), 64'd0);
        n = 0; while (input_a_stb && n < 20) begin tick(); n++; end
        chk("a_ack_gap", 64'(n), 64'd3);
        chk("zack_after_a", 64'(output_z_ack), 64'd1);
        drain(100);
        a_delay = 0;

        // Overflow: six back-to-back pushes against a stalled core.
        do_reset();
        hold_ab = 1;
        for (int i = 0; i < 6; i++) begin
            ra = rnd_double(); rb = rnd_double(); rs = 1'($urandom_range(0, 1));
            push(ra, rb, rs, TAG_W'(i), i < 5, ref_result(ra, rb, rs));
            chk("ovf_count", 64'(count), 64'(exp_cnt[i]));
            if (i == 4) chk("ovf_dropped_before", 64'(dropped), 64'd0);
        end
        chk("ovf_full", 64'(full), 64'd1);
        chk("ovf_dropped", 64'(dropped), 64'd1);
        hold_ab = 0; pulses = 0;
        drain(200);
        chk("ovf_pulses", 64'(pulses), 64'd5);
        chk("ovf_count_end", 64'(count), 64'd0);

        // Push coinciding with pop, at count 4 then at count 3.
        do_reset();
        hold_ab = 1;
        for (int i = 0; i < 5; i++) begin
            ra = rnd_double(); rb = rnd_double();
            push(ra, rb, 1'b0, TAG_W'(i), 1, ref_result(ra, rb, 1'b0));
        end
        chk("pp_count4", 64'(count), 64'd4);
        chk("pp_full", 64'(full), 64'd1);
        hold_ab = 0;
        wait_ready_out(50);
        tick();
        chk("pp_dropped_before", 64'(dropped), 64'd0);
        push(rnd_double(), rnd_double(), 1'b0, 4'd8, 0, 64'd0);
        chk("pp_rejected_count", 64'(count), 64'd3);
        chk("pp_rejected_dropped", 64'(dropped), 64'd1);
        wait_ready_out(50);
        tick();
        ra = rnd_double(); rb = rnd_double();
        push(ra, rb, 1'b1, 4'd9, 1, ref_result(ra, rb, 1'b1));
        chk("pp_accepted_count", 64'(count), 64'd3);
        drain(200);

        // Reset while a result is pending in WAIT_Z.
        do_reset();
        hold_z = 1;
        for (int i = 0; i < 3; i++) begin
            ra = rnd_double(); rb = rnd_double();
            push(ra, rb, 1'b0, TAG_W'(i), 1, ref_result(ra, rb, 1'b0));
        end
        n = 0; while (!output_z_ack && n < 20) begin tick(); n++; end
        chk("mid_count", 64'(count), 64'd2);
        chk("mid_z_ack", 64'(output_z_ack), 64'd1);
        do_reset();
        hold_z = 0;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_z_ack", 64'(output_z_ack), 64'd0);
        repeat (10) tick();
        push(64'h3FF3AE147AE147AE, 64'h40123D70A3D70A3D, 1'b0, 4'd7, 1, 64'h401728F5C28F5C28);
        drain(100);

        // Randomized traffic with random core timing.
        for (int i = 0; i < 40; i++) begin
            a_delay = $urandom_range(0, 3);
            b_delay = $urandom_range(0, 3);
            z_delay = $urandom_range(0, 3);
            repeat ($urandom_range(0, 2)) tick();
            if (exp_z.size() < DEPTH) begin
                ra = rnd_double(); rb = rnd_double(); rs = 1'($urandom_range(0, 1));
                push(ra, rb, rs, TAG_W'(i), 1, ref_result(ra, rb, rs));
            end else tick();
        end
        drain(400);
        chk("rand_dropped", 64'(dropped), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
